// File: rtl/timer_regfile_pkg.sv
// Shared register map, field positions and reset constants for the timer register front end.
package timer_regfile_pkg;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned TIMER_W    = 64;
    localparam int unsigned BYTE_SEL_W = 3;
    localparam int unsigned BIT_OFS_W  = BYTE_SEL_W + 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL       = 5'h00;
    localparam logic [ADDR_W-1:0] ADDR_STATUS     = 5'h01;
    localparam logic [ADDR_W-1:0] ADDR_CMP_BASE   = 5'h08;
    localparam logic [ADDR_W-1:0] ADDR_COUNT_BASE = 5'h10;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_CLR_BIT     = 1;
    localparam int unsigned CTRL_IRQEN_BIT   = 2;
    localparam int unsigned STATUS_MATCH_BIT = 0;

    localparam logic [TIMER_W-1:0] CMP_RESET = '1;

    // True when addr falls inside the 8-byte window starting at base.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base);
        return addr[ADDR_W-1:BYTE_SEL_W] == base[ADDR_W-1:BYTE_SEL_W];
    endfunction

endpackage

// File: rtl/timer_regfile_if.sv
// Byte-wide processor bus between a bus master and the timer register front end.
interface timer_regfile_if;
    import timer_regfile_pkg::*;

    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, bus_rvalid
    );

endinterface

// File: rtl/timer_irq_edge.sv
// Rising-edge detect on the timer match level, sticky W1C MATCH flag and masked registered irq.
module timer_irq_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic match_lvl_i,
    input  logic w1c_i,
    input  logic irqen_i,
    output logic match_o,
    output logic irq_o
);

    logic prev_q;
    logic match_q;
    logic match_d;
    logic irq_q;

    // A new rise beats a simultaneous clear.
    assign match_d = (match_lvl_i & ~prev_q) | (match_q & ~w1c_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            prev_q  <= match_lvl_i;
            match_q <= match_d;
            irq_q   <= match_q & irqen_i;
        end
    end

    assign match_o = match_q;
    assign irq_o   = irq_q;

endmodule

// File: rtl/timer_regfile.sv
// Byte-wide register front end for the 64-bit timer: control byte, shadowed compare
// with commit on byte 7, atomic count snapshot, and sticky maskable match interrupt.
module timer_regfile
    import timer_regfile_pkg::*;
(
    input  logic               clock,
    input  logic               nreset,
    timer_regfile_if.slave     bus,
    output logic [DATA_W-1:0]  control_reg,
    output logic [TIMER_W-1:0] timer_compare_value,
    input  logic [TIMER_W-1:0] timer_value,
    input  logic               timer_compare_match,
    output logic               irq
);

    logic                  en_q, en_d;
    logic                  irqen_q, irqen_d;
    logic                  clr_q, clr_d;
    logic [TIMER_W-1:0]    shadow_q, shadow_d;
    logic [TIMER_W-1:0]    cmp_q, cmp_d;
    logic [TIMER_W-1:0]    snap_q, snap_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  rvalid_q;
    logic                  match;
    logic                  status_w1c;
    logic                  sel_ctrl, sel_status, sel_cmp, sel_count;
    logic [BYTE_SEL_W-1:0] byte_sel;
    logic [BIT_OFS_W-1:0]  bit_ofs;

    assign byte_sel   = bus.bus_addr[BYTE_SEL_W-1:0];
    assign bit_ofs    = {byte_sel, 3'b000};
    assign sel_ctrl   = (bus.bus_addr == ADDR_CTRL);
    assign sel_status = (bus.bus_addr == ADDR_STATUS);
    assign sel_cmp    = in_window(bus.bus_addr, ADDR_CMP_BASE);
    assign sel_count  = in_window(bus.bus_addr, ADDR_COUNT_BASE);
    assign status_w1c = bus.bus_we & sel_status & bus.bus_wdata[STATUS_MATCH_BIT];

    // Write side and read mux; reads see the pre-write register state.
    always_comb begin
        en_d     = en_q;
        irqen_d  = irqen_q;
        clr_d    = 1'b0;
        shadow_d = shadow_q;
        cmp_d    = cmp_q;
        snap_d   = snap_q;
        rdata_d  = rdata_q;

        if (bus.bus_we) begin
            if (sel_ctrl) begin
                en_d    = bus.bus_wdata[CTRL_EN_BIT];
                irqen_d = bus.bus_wdata[CTRL_IRQEN_BIT];
                clr_d   = bus.bus_wdata[CTRL_CLR_BIT];
            end
            if (sel_cmp) begin
                shadow_d[bit_ofs +: DATA_W] = bus.bus_wdata;
                if (byte_sel == BYTE_SEL_W'(7)) begin
                    cmp_d = shadow_d;
                end
            end
        end

        if (bus.bus_re) begin
            rdata_d = '0;
            if (sel_ctrl) begin
                rdata_d = {5'b0, irqen_q, 1'b0, en_q};
            end else if (sel_status) begin
                rdata_d = {7'b0, match};
            end else if (sel_cmp) begin
                rdata_d = shadow_q[bit_ofs +: DATA_W];
            end else if (sel_count) begin
                if (byte_sel == '0) begin
                    rdata_d = timer_value[DATA_W-1:0];
                    snap_d  = timer_value;
                end else begin
                    rdata_d = snap_q[bit_ofs +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            en_q     <= 1'b0;
            irqen_q  <= 1'b0;
            clr_q    <= 1'b0;
            shadow_q <= CMP_RESET;
            cmp_q    <= CMP_RESET;
            snap_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            en_q     <= en_d;
            irqen_q  <= irqen_d;
            clr_q    <= clr_d;
            shadow_q <= shadow_d;
            cmp_q    <= cmp_d;
            snap_q   <= snap_d;
            rdata_q  <= rdata_d;
            rvalid_q <= bus.bus_re;
        end
    end

    timer_irq_edge u_irq_edge (
        .clk         (clock),
        .rst_n       (nreset),
        .match_lvl_i (timer_compare_match),
        .w1c_i       (status_w1c),
        .irqen_i     (irqen_q),
        .match_o     (match),
        .irq_o       (irq)
    );

    assign control_reg         = {{(DATA_W-2){1'b0}}, clr_q, en_q};
    assign timer_compare_value = cmp_q;
    assign bus.bus_rdata       = rdata_q;
    assign bus.bus_rvalid      = rvalid_q;

endmodule

// File: tb/tb_timer_regfile.sv
// Self-checking bench for timer_regfile: directed vector table, multi-cycle irq/reset
// sequences, and random traffic against a register-map level reference model.
module tb_timer_regfile;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [7:0]  control_reg;
    logic [63:0] timer_compare_value;
    logic [63:0] timer_value = '0;
    logic        timer_compare_match = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_regfile_if bus ();

    timer_regfile dut (
        .clock               (clk),
        .nreset              (nreset),
        .bus                 (bus),
        .control_reg         (control_reg),
        .timer_compare_value (timer_compare_value),
        .timer_value         (timer_value),
        .timer_compare_match (timer_compare_match),
        .irq                 (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, let one rising edge pass, sample 1 ns later.
    task automatic cyc(input bit we, input bit re, input logic [4:0] a, input logic [7:0] d);
        bus.bus_we    = we;
        bus.bus_re    = re;
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        @(posedge clk);
        #1;
        bus.bus_we = 1'b0;
        bus.bus_re = 1'b0;
    endtask

    task automatic do_reset();
        bus.bus_we = 1'b0;
        bus.bus_re = 1'b0;
        bus.bus_addr = '0;
        bus.bus_wdata = '0;
        timer_compare_match = 1'b0;
        timer_value = '0;
        nreset = 1'b0;
        #12;
        @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    // ---------------- reference model (register-map semantics) ----------------
    bit          m_en, m_irqen, m_clr, m_match, m_prev, m_irq, m_rvalid;
    logic [7:0]  m_shadow [8];
    logic [63:0] m_cmp, m_snap;
    logic [7:0]  m_rdata;

    function automatic void model_reset();
        m_en = 0; m_irqen = 0; m_clr = 0; m_match = 0; m_prev = 0; m_irq = 0; m_rvalid = 0;
        for (int k = 0; k < 8; k++) m_shadow[k] = 8'hFF;
        m_cmp = '1;
        m_snap = '0;
        m_rdata = '0;
    endfunction

    function automatic logic [7:0] model_read(input int ai, input logic [63:0] tv);
        logic [63:0] t;
        if (ai == 0) return {5'b0, m_irqen, 1'b0, m_en};
        if (ai == 1) return {7'b0, m_match};
        if (ai >= 8 && ai <= 15) return m_shadow[ai-8];
        if (ai == 16) return tv[7:0];
        if (ai >= 17 && ai <= 23) begin
            t = m_snap >> (8 * (ai - 16));
            return t[7:0];
        end
        return 8'h00;
    endfunction

    function automatic void model_edge(input bit we, input bit re, input int ai,
                                       input logic [7:0] d, input logic [63:0] tv, input bit tcm);
        bit old_match = m_match;
        bit old_irqen = m_irqen;
        bit w1c = we && ai == 1 && d[0];
        if (re) begin
            m_rdata = model_read(ai, tv);
            if (ai == 16) m_snap = tv;
        end
        m_rvalid = re;
        m_clr = 0;
        if (we && ai == 0) begin
            m_en = d[0];
            m_clr = d[1];
            m_irqen = d[2];
        end
        if (we && ai >= 8 && ai <= 15) begin
            m_shadow[ai-8] = d;
            if (ai == 15) for (int k = 0; k < 8; k++) m_cmp[8*k +: 8] = m_shadow[k];
        end
        m_irq = old_match && old_irqen;
        m_match = (tcm && !m_prev) || (old_match && !w1c);
        m_prev = tcm;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          we;
        bit          re;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic [63:0] tv;
        logic [7:0]  exp_ctrl;
        logic [63:0] exp_cmp;
        bit          exp_rvalid;
        logic [7:0]  exp_rdata;
    } vec_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] TVA  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] TVB  = 64'hAABB_CCDD_EEFF_0011;
    localparam logic [63:0] C5   = 64'h0000_0000_0000_0005;
    localparam logic [63:0] C12  = 64'h1200_0000_0000_0005;

    vec_t vecs [20];

    initial begin
        bit          we, re, tcm;
        logic [4:0]  a;
        logic [7:0]  d;
        logic [63:0] tv;

        // Reset state
        do_reset();
        check("rst_ctrl", control_reg, 8'h00);
        check("rst_cmp", timer_compare_value, ONES);
        check("rst_irq", irq, 1'b0);
        check("rst_rvalid", bus.bus_rvalid, 1'b0);
        check("rst_rdata", bus.bus_rdata, 8'h00);

        vecs[0]  = '{1, 0, 5'h08, 8'h05, 64'h0, 8'h00, ONES, 0, 8'h00};
        vecs[1]  = '{1, 0, 5'h09, 8'h00, 64'h0, 8'h00, ONES, 0, 8'h00};
        vecs[2]  = '{1, 0, 5'h0A, 8'h00, 64'h0, 8'h00, ONES, 0, 8'h00};
        vecs[3]  = '{1, 0, 5'h0B, 8'h00, 64'h0, 8'h00, ONES, 0, 8'h00};
        vecs[4]  = '{1, 0, 5'h0C, 8'h00, 64'h0, 8'h00, ONES, 0, 8'h00};
        vecs[5]  = '{1, 0, 5'h0D, 8'h00, 64'h0, 8'h00, ONES, 0, 8'h00};
        vecs[6]  = '{1, 0, 5'h0E, 8'h00, 64'h0, 8'h00, ONES, 0, 8'h00};
        vecs[7]  = '{1, 0, 5'h0F, 8'h00, 64'h0, 8'h00, C5,   0, 8'h00};
        vecs[8]  = '{0, 1, 5'h08, 8'h00, 64'h0, 8'h00, C5,   1, 8'h05};
        vecs[9]  = '{1, 0, 5'h00, 8'h03, 64'h0, 8'h03, C5,   0, 8'h05};
        vecs[10] = '{0, 0, 5'h00, 8'h00, 64'h0, 8'h01, C5,   0, 8'h05};
        vecs[11] = '{0, 1, 5'h00, 8'h00, 64'h0, 8'h01, C5,   1, 8'h01};
        vecs[12] = '{0, 1, 5'h10, 8'h00, TVA,   8'h01, C5,   1, 8'h88};
        vecs[13] = '{0, 1, 5'h17, 8'h00, TVB,   8'h01, C5,   1, 8'h11};
        vecs[14] = '{0, 1, 5'h13, 8'h00, TVB,   8'h01, C5,   1, 8'h55};
        vecs[15] = '{0, 0, 5'h13, 8'h00, TVB,   8'h01, C5,   0, 8'h55};
        vecs[16] = '{0, 1, 5'h05, 8'h00, TVB,   8'h01, C5,   1, 8'h00};
        vecs[17] = '{1, 1, 5'h0F, 8'h12, TVB,   8'h01, C12,  1, 8'h00};
        vecs[18] = '{0, 1, 5'h0F, 8'h00, TVB,   8'h01, C12,  1, 8'h12};
        vecs[19] = '{1, 1, 5'h05, 8'hFF, TVB,   8'h01, C12,  1, 8'h00};

        foreach (vecs[i]) begin
            timer_value = vecs[i].tv;
            cyc(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_ctrl", i), control_reg, vecs[i].exp_ctrl);
            check($sformatf("vec%0d_cmp", i), timer_compare_value, vecs[i].exp_cmp);
            check($sformatf("vec%0d_rvalid", i), bus.bus_rvalid, vecs[i].exp_rvalid);
            check($sformatf("vec%0d_rdata", i), bus.bus_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_irq", i), irq, 1'b0);
        end

        // Async reset mid-sequence discards a partial shadow
        cyc(1, 0, 5'h08, 8'hAA);
        cyc(1, 0, 5'h09, 8'hBB);
        #2;
        nreset = 1'b0;
        #1;
        check("arst_ctrl", control_reg, 8'h00);
        check("arst_cmp", timer_compare_value, ONES);
        check("arst_rdata", bus.bus_rdata, 8'h00);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        cyc(1, 0, 5'h0F, 8'h00);
        check("arst_commit", timer_compare_value, 64'h00FF_FFFF_FFFF_FFFF);

        // Match rise held high: one MATCH, irq one cycle later, W1C with level still high
        cyc(1, 0, 5'h00, 8'h04);
        timer_compare_match = 1'b1;
        cyc(0, 0, 5'h00, 8'h00);
        check("irq_lag", irq, 1'b0);
        cyc(0, 0, 5'h00, 8'h00);
        check("irq_set", irq, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 5'h00, 8'h00);
            check("irq_hold", irq, 1'b1);
        end
        cyc(0, 1, 5'h01, 8'h00);
        check("status_set", bus.bus_rdata, 8'h01);
        cyc(1, 0, 5'h01, 8'h01);
        check("w1c_irq_lag", irq, 1'b1);
        cyc(0, 0, 5'h00, 8'h00);
        check("w1c_irq_drop", irq, 1'b0);
        cyc(0, 1, 5'h01, 8'h00);
        check("w1c_no_reset", bus.bus_rdata, 8'h00);
        check("w1c_irq_low", irq, 1'b0);

        // W1C coincident with a new rise: set wins
        timer_compare_match = 1'b0;
        cyc(0, 0, 5'h00, 8'h00);
        timer_compare_match = 1'b1;
        cyc(0, 0, 5'h00, 8'h00);
        timer_compare_match = 1'b0;
        cyc(0, 0, 5'h00, 8'h00);
        check("race_irq_pre", irq, 1'b1);
        timer_compare_match = 1'b1;
        cyc(1, 0, 5'h01, 8'h01);
        check("race_irq_a", irq, 1'b1);
        cyc(0, 0, 5'h00, 8'h00);
        check("race_irq_b", irq, 1'b1);
        cyc(0, 1, 5'h01, 8'h00);
        check("race_status", bus.bus_rdata, 8'h01);

        // Masking: irq follows IRQEN one cycle late while MATCH stays pending
        cyc(1, 0, 5'h00, 8'h00);
        check("mask_lag", irq, 1'b1);
        cyc(0, 0, 5'h00, 8'h00);
        check("mask_off", irq, 1'b0);
        cyc(1, 0, 5'h00, 8'h04);
        check("unmask_lag", irq, 1'b0);
        cyc(0, 0, 5'h00, 8'h00);
        check("unmask_on", irq, 1'b1);

        // Edge detection keeps running while masked
        cyc(1, 0, 5'h01, 8'h01);
        cyc(1, 0, 5'h00, 8'h00);
        timer_compare_match = 1'b0;
        cyc(0, 0, 5'h00, 8'h00);
        timer_compare_match = 1'b1;
        cyc(0, 0, 5'h00, 8'h00);
        cyc(0, 0, 5'h00, 8'h00);
        check("masked_irq", irq, 1'b0);
        cyc(0, 1, 5'h01, 8'h00);
        check("masked_status", bus.bus_rdata, 8'h01);

        // Random traffic against the reference model
        do_reset();
        model_reset();
        tcm = 1'b0;
        for (int i = 0; i < 600; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 5'($urandom_range(0, 31));
                1: a = 5'($urandom_range(0, 1));
                2: a = 5'(8 + $urandom_range(0, 7));
                default: a = 5'(16 + $urandom_range(0, 7));
            endcase
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) tcm = ~tcm;
            tv = {$urandom, $urandom};
            timer_value = tv;
            timer_compare_match = tcm;
            model_edge(we, re, int'(a), d, tv, tcm);
            cyc(we, re, a, d);
            check("rnd_ctrl", control_reg, {6'b0, m_clr, m_en});
            check("rnd_cmp", timer_compare_value, m_cmp);
            check("rnd_irq", irq, m_irq);
            check("rnd_rvalid", bus.bus_rvalid, m_rvalid);
            check("rnd_rdata", bus.bus_rdata, m_rdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
